vga_vram_arbiter: RTL and testbench
===================================

Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters.
  - Display fetch port: reads pixels ahead of the VGA timing generator.
  - Drawing port: GPU read/write.
- Display has priority during the active area. Drawing has priority during blanking.
- A starvation counter guarantees the drawing port progress during long active periods.
- Read data is returned to the requester that issued the read.

Parameters:
- addr_width, 16, VRAM address width.
- data_width, 8, VRAM data width.
- mem_latency, 1, cycles from mem_en sampled by RAM to mem_rdata valid (>=1).
- starve_limit, 8, consecutive stalled GPU cycles before the GPU is forced a grant in the active area (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- blanking  in  1  high while the timing generator is outside the visible area.
- disp_req  in  1  display read request.
- disp_addr  in  addr_width  display read address, stable while disp_req && !disp_ack.
- disp_ack  out  1  display request accepted this cycle.
- disp_rdata  out  data_width  display read data.
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse per accepted read.
- gpu_req  in  1  GPU request.
- gpu_we  in  1  1 = write, 0 = read.
- gpu_addr  in  addr_width  GPU address.
- gpu_wdata  in  data_width  GPU write data.
- gpu_ack  out  1  GPU request accepted this cycle.
- gpu_rdata  out  data_width  GPU read data.
- gpu_rvalid  out  1  gpu_rdata valid, one-cycle pulse per accepted GPU read.
- mem_en  out  1  RAM access strobe (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  addr_width  RAM address (registered).
- mem_wdata  out  data_width  RAM write data (registered).
- mem_rdata  in  data_width  RAM read data.

Behaviour:

Handshake:
- A transfer occurs on a rising edge where req && ack.
- ack is combinational from req, blanking and starvation state.
- At most one of disp_ack/gpu_ack is high per cycle.
- The requester holds req, addr, we and wdata until acked, and may present the next request in the following cycle. Back-to-back grants to the same port are allowed (one access per cycle).

Arbitration (each cycle):
- blanking=1: gpu_req wins; otherwise disp_req.
- blanking=0 and starve_cnt == starve_limit: gpu_req wins.
- blanking=0 otherwise: disp_req wins; gpu granted only if !disp_req.
- No request: no ack, mem_en=0 next cycle.

starve_cnt (width clog2(starve_limit+1)):
- Increments each cycle gpu_req && !gpu_ack, saturating at starve_limit.
- Clears to 0 on gpu_ack or when !gpu_req.

Memory side:
- The cycle after a grant, mem_en=1, with mem_we = gpu_we for GPU grants and 0 for display grants. mem_addr/mem_wdata take the granted requester's values.
- Outputs hold previous values when idle, except mem_en=0 and mem_we=0.

Read return tagging:
- A shift register of depth mem_latency carries {valid, owner}. An entry is pushed on every mem_en with !mem_we; writes push valid=0.
- When the entry exits, mem_rdata is copied to the owner's rdata output and the owner's rvalid pulses for one cycle.
- Read latency from handshake edge to rvalid high is 1 + mem_latency cycles. With the default, rvalid is high 2 cycles after the ack cycle.
- rdata holds its last value between pulses.
- Reads return in issue order. Interleaved owners are never swapped.

Reset (asynchronous, active-low):
- Sets mem_en, mem_we, disp_rvalid, gpu_rvalid to 0; mem_addr, mem_wdata, disp_rdata, gpu_rdata to 0; starve_cnt to 0; all tag entries invalid.
- ack outputs are forced 0 while reset is low.
- Reset mid-operation: in-flight reads are discarded. No rvalid appears after reset is released for reads issued before it.

Boundary conditions:
- blanking toggling with both requests pending takes effect in the same cycle.
- A starvation grant consumes one cycle; disp wins again the next cycle.
- gpu_req dropping while stalled clears starve_cnt.

Test Plan:
- Reset then idle: mem_en=0, acks 0, rvalids 0 for 10 cycles. Assert reset for 1 cycle mid-read: no rvalid follows.
- blanking=0, disp_req continuous, addrs 0x0000..0x0003: disp_ack every cycle, mem_addr 0x0000..0x0003 one cycle later. With mem_rdata = addr low byte, disp_rdata 0x00..0x03 with disp_rvalid, 2 cycles after each ack.
- blanking=0, disp_req and gpu_req (write 0x1234 <- 0xAB) both continuous, starve_limit=8: gpu_ack in the 9th cycle only; mem_we=1, mem_addr=0x1234, mem_wdata=0xAB next cycle; disp resumes following cycle.
- blanking=1, both requesting: gpu_ack immediately every cycle; disp_ack only after gpu_req drops.
- Interleaved reads gpu@0x0010, disp@0x0020, gpu@0x0030 (blanking alternated to force order): rvalids return in the same order with matching data on the correct ports; no cross-delivery.
- GPU write followed by GPU read of the same address: gpu_rvalid only for the read, returning the written value from a RAM model; no gpu_rvalid for the write.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// Two-port arbiter in front of a single-port video RAM: display fetch and GPU
// drawing share one access per cycle, with read data routed back to its issuer.
module vga_vram_arbiter #(
    parameter int addr_width   = 16,
    parameter int data_width   = 8,
    parameter int mem_latency  = 1,
    parameter int starve_limit = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blanking,
    input  logic                  disp_req,
    input  logic [addr_width-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [data_width-1:0] disp_rdata,
    output logic                  disp_rvalid,
    input  logic                  gpu_req,
    input  logic                  gpu_we,
    input  logic [addr_width-1:0] gpu_addr,
    input  logic [data_width-1:0] gpu_wdata,
    output logic                  gpu_ack,
    output logic [data_width-1:0] gpu_rdata,
    output logic                  gpu_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata
);

    localparam int cnt_width = $clog2(starve_limit + 1);
    localparam logic [cnt_width-1:0] starve_max = cnt_width'(starve_limit);

    typedef enum logic {
        owner_disp = 1'b0,
        owner_gpu  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    logic [cnt_width-1:0] starve_cnt;
    logic                 gpu_win;
    owner_t               mem_owner;
    tag_t                 tag_pipe [mem_latency];
    tag_t                 tag_exit;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gpu_win  = 1'b0;
        gpu_ack  = 1'b0;
        disp_ack = 1'b0;
        gpu_win  = gpu_req && (blanking || (starve_cnt == starve_max) || !disp_req);
        gpu_ack  = reset && gpu_win;
        disp_ack = reset && disp_req && !gpu_win;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (gpu_req && !gpu_ack) begin
            if (starve_cnt != starve_max)
                starve_cnt <= starve_cnt + cnt_width'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_owner <= owner_disp;
        end else if (gpu_ack) begin
            mem_en    <= 1'b1;
            mem_we    <= gpu_we;
            mem_addr  <= gpu_addr;
            mem_wdata <= gpu_wdata;
            mem_owner <= owner_gpu;
        end else if (disp_ack) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= disp_addr;
            mem_owner <= owner_disp;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // NOTE: the tag pipeline is reset on purpose, unlike a data memory: any
    // stale valid bit would deliver a phantom rvalid after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < mem_latency; i++)
                tag_pipe[i] <= '{valid: 1'b0, owner: owner_disp};
        end else begin
            for (int i = mem_latency - 1; i > 0; i--)
                tag_pipe[i] <= tag_pipe[i-1];
            tag_pipe[0] <= '{valid: mem_en && !mem_we, owner: mem_owner};
        end
    end

    assign tag_exit = tag_pipe[mem_latency-1];

    // The exiting tag lines up with the RAM data for the read it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_rvalid <= 1'b0;
            gpu_rvalid  <= 1'b0;
            disp_rdata  <= '0;
            gpu_rdata   <= '0;
        end else begin
            disp_rvalid <= tag_exit.valid && (tag_exit.owner == owner_disp);
            gpu_rvalid  <= tag_exit.valid && (tag_exit.owner == owner_gpu);
            if (tag_exit.valid && (tag_exit.owner == owner_disp))
                disp_rdata <= mem_rdata;
            if (tag_exit.valid && (tag_exit.owner == owner_gpu))
                gpu_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomized and directed bench for vga_vram_arbiter against a transaction-level
// model: arbitration rules, registered RAM strobes and tagged read returns.
module tb_vga_vram_arbiter;

    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        blanking;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_ack;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        gpu_req;
    logic        gpu_we;
    logic [15:0] gpu_addr;
    logic [7:0]  gpu_wdata;
    logic        gpu_ack;
    logic [7:0]  gpu_rdata;
    logic        gpu_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    vga_vram_arbiter #(
        .addr_width(16), .data_width(8), .mem_latency(1), .starve_limit(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .blanking(blanking),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
        .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata), .gpu_rvalid(gpu_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one cycle read latency, preloaded with addr[7:0].
    logic [7:0] ram [65536];
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Transaction-level reference state.
    typedef struct {
        bit         gpu;
        logic [7:0] data;
        int         due;
    } rd_t;

    logic [7:0]  ref_mem [65536];
    rd_t         rq [$];
    int          starve;
    bit          exp_en, exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata, exp_disp_rdata, exp_gpu_rdata;
    int          cyc;
    bit          obs_disp_ack, obs_gpu_ack;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        starve         = 0;
        exp_en         = 1'b0;
        exp_we         = 1'b0;
        exp_addr       = '0;
        exp_wdata      = '0;
        exp_disp_rdata = '0;
        exp_gpu_rdata  = '0;
    endtask

    // One clock cycle: inputs are already driven; check acks, advance, check registered outputs.
    task automatic step();
        bit exp_ga, exp_da, exp_dv, exp_gv;
        #1;
        exp_ga = reset && gpu_req && (blanking || starve == STARVE_LIMIT || !disp_req);
        exp_da = reset && disp_req && !exp_ga;
        check("disp_ack", disp_ack, exp_da);
        check("gpu_ack", gpu_ack, exp_ga);
        obs_disp_ack = disp_ack;
        obs_gpu_ack  = gpu_ack;
        @(posedge clk);
        #1;
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            if (exp_ga) begin
                exp_en = 1'b1; exp_we = gpu_we; exp_addr = gpu_addr; exp_wdata = gpu_wdata;
                if (gpu_we) ref_mem[gpu_addr] = gpu_wdata;
                else rq.push_back('{gpu: 1'b1, data: ref_mem[gpu_addr], due: cyc + 2});
            end else if (exp_da) begin
                exp_en = 1'b1; exp_we = 1'b0; exp_addr = disp_addr;
                rq.push_back('{gpu: 1'b0, data: ref_mem[disp_addr], due: cyc + 2});
            end else begin
                exp_en = 1'b0; exp_we = 1'b0;
            end
            if (gpu_req && !exp_ga) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
            else starve = 0;
        end
        exp_dv = 1'b0;
        exp_gv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].gpu) begin exp_gv = 1'b1; exp_gpu_rdata = rq[0].data; end
            else begin exp_dv = 1'b1; exp_disp_rdata = rq[0].data; end
            void'(rq.pop_front());
        end
        check("mem_en", mem_en, exp_en);
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("disp_rvalid", disp_rvalid, exp_dv);
        check("gpu_rvalid", gpu_rvalid, exp_gv);
        check("disp_rdata", disp_rdata, exp_disp_rdata);
        check("gpu_rdata", gpu_rdata, exp_gpu_rdata);
    endtask

    task automatic idle(input int n);
        disp_req = 1'b0;
        gpu_req  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic gpu_cmd(input bit we, input logic [15:0] addr, input logic [7:0] wdata);
        gpu_req = 1'b1; gpu_we = we; gpu_addr = addr; gpu_wdata = wdata;
    endtask

    initial begin
        int n;
        for (int a = 0; a < 65536; a++) begin
            ram[a]     = a[7:0];
            ref_mem[a] = a[7:0];
        end
        cyc = 0;
        model_reset();
        reset = 1'b0; blanking = 1'b0;
        disp_req = 1'b1; disp_addr = 16'h0005;
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 16'h0006; gpu_wdata = 8'h00;

        // Requests held during reset must not be acknowledged.
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        idle(10);

        // Continuous display fetch of 0x0000..0x0003.
        for (int i = 0; i < 4; i++) begin
            disp_req = 1'b1; disp_addr = 16'(i);
            step();
        end
        idle(4);

        // Starvation grant: GPU write wins exactly on the 9th contended cycle.
        disp_req = 1'b1; disp_addr = 16'h0100;
        gpu_cmd(1'b1, 16'h1234, 8'hAB);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n++;
            step();
            if (obs_disp_ack) disp_addr = disp_addr + 16'd1;
            if (obs_gpu_ack) break;
        end
        check("starve_grant_cycle", n, STARVE_LIMIT + 1);
        gpu_req = 1'b0;
        step();
        check("disp_after_starve", obs_disp_ack, 1'b1);
        idle(4);

        // Dropping gpu_req while stalled restarts the starvation count.
        disp_req = 1'b1;
        gpu_cmd(1'b0, 16'h0200, 8'h00);
        for (int i = 0; i < 5; i++) step();
        gpu_req = 1'b0;
        step();
        gpu_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n++;
            step();
            if (obs_gpu_ack) break;
        end
        check("starve_restart_cycle", n, STARVE_LIMIT + 1);
        idle(4);

        // Blanking: GPU wins every cycle, display only once the GPU stops asking.
        blanking = 1'b1;
        disp_req = 1'b1; disp_addr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            gpu_cmd(1'b0, 16'h0400 + 16'(i), 8'h00);
            step();
        end
        gpu_req = 1'b0;
        step();
        check("blank_disp_after_gpu", obs_disp_ack, 1'b1);
        idle(4);

        // Interleaved owners: gpu@0x10, disp@0x20, gpu@0x30.
        blanking = 1'b1; disp_req = 1'b1; disp_addr = 16'h0020;
        gpu_cmd(1'b0, 16'h0010, 8'h00);
        step();
        blanking = 1'b0; gpu_addr = 16'h0030;
        step();
        blanking = 1'b1; disp_req = 1'b0;
        step();
        idle(4);

        // GPU write then read of the same address.
        gpu_cmd(1'b1, 16'h0040, 8'h5A);
        step();
        gpu_cmd(1'b0, 16'h0040, 8'h00);
        step();
        idle(4);
        check("raw_read_data", gpu_rdata, 8'h5A);

        // Reset pulse one cycle after a read grant: the read never returns.
        blanking = 1'b0; disp_req = 1'b1; disp_addr = 16'h0050;
        step();
        disp_req = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        idle(5);

        // Randomized traffic with protocol-following requesters.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) blanking = ~blanking;
            if (!disp_req || obs_disp_ack) begin
                disp_req  = ($urandom_range(3) != 0);
                disp_addr = 16'($urandom_range(63));
            end
            if (!gpu_req || obs_gpu_ack) begin
                gpu_req   = ($urandom_range(2) != 0);
                gpu_we    = $urandom_range(1) != 0;
                gpu_addr  = 16'($urandom_range(63));
                gpu_wdata = 8'($urandom);
            end else if ($urandom_range(15) == 0) begin
                gpu_req = 1'b0;
            end
            step();
        end
        idle(5);
        check("read_queue_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
